// File: rtl/led_blinker_pkg.sv
// ---------------------------------------------------------------------------
// led_blinker_pkg
// Shared constants for the multi-channel LED blinker:
//   NUM_RATES / RATE_SEL_W   - number of shared rate generators and select width
//   rate_sel_e               - rate select encodings (0..3 = 100/50/10/1 Hz)
//   C_RATEk_DEF              - default half-periods in clocks for a 25 MHz clock
// ---------------------------------------------------------------------------
package led_blinker_pkg;

  localparam int NUM_RATES  = 4;
  localparam int RATE_SEL_W = 2;

  typedef enum logic [RATE_SEL_W-1:0] {
    RATE_100HZ = 2'd0,
    RATE_50HZ  = 2'd1,
    RATE_10HZ  = 2'd2,
    RATE_1HZ   = 2'd3
  } rate_sel_e;

  // Half-periods (clock cycles) at 25 MHz.
  localparam int unsigned C_RATE0_DEF = 32'd125000;    // 100 Hz
  localparam int unsigned C_RATE1_DEF = 32'd250000;    //  50 Hz
  localparam int unsigned C_RATE2_DEF = 32'd1250000;   //  10 Hz
  localparam int unsigned C_RATE3_DEF = 32'd12500000;  //   1 Hz

endpackage

// File: rtl/led_rate_gen.sv
// ---------------------------------------------------------------------------
// led_rate_gen
// One shared square-wave generator: a free-running counter that wraps every
// C_HALF clocks and toggles the square output on each wrap, giving a
// 2*C_HALF-cycle period at 50% duty. The first rise lands on the C_HALF-th
// rising edge with i_enable high.
// Parameters: CNT_W (counter width), C_HALF (half-period, 2 .. 2**CNT_W-1)
// Ports:
//   i_clock    - clock, rising edge
//   i_reset_n  - asynchronous active-low reset
//   i_enable   - run; low clears counter and square
//   o_sq       - registered square wave
// ---------------------------------------------------------------------------
module led_rate_gen #(
  parameter int          CNT_W  = 32,
  parameter int unsigned C_HALF = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_enable,
  output logic o_sq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_HALF - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt  <= '0;
      o_sq <= 1'b0;
    end else if (!i_enable) begin
      cnt  <= '0;
      o_sq <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      o_sq <= ~o_sq;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_blinker_multi.sv
// ---------------------------------------------------------------------------
// led_blinker_multi
// Four shared rate generators feed N_CH independent LED channels. Each channel
// selects one rate and has its own enable. A rate change requested while the
// channel's LED is high is held pending until the currently selected square
// returns low, so a high pulse is never truncated; the latest request wins.
//
// Optional build macro: LED_BLINKER_MULTI_SYNC_EN
//   defined   - i_enable, i_ch_enable, i_rate_sel pass through a 2-flop
//               synchroniser (reset to 0); all input-to-output latencies +2.
//   undefined - inputs are used directly (assumed synchronous to i_clock).
//
// Ports:
//   i_clock      - clock, rising edge
//   i_reset_n    - asynchronous active-low reset
//   i_enable     - global run; low clears all generators and LEDs
//   i_ch_enable  - per-channel enable [N_CH]
//   i_rate_sel   - per-channel rate select, channel n = bits [2n+1:2n]
//   o_led_drive  - registered LED drive, active high [N_CH]
//   o_dbg_rate   - raw square of each rate generator [4]
// ---------------------------------------------------------------------------
module led_blinker_multi
  import led_blinker_pkg::*;
#(
  parameter int          N_CH    = 4,
  parameter int          CNT_W   = 32,
  parameter int unsigned C_RATE0 = C_RATE0_DEF,
  parameter int unsigned C_RATE1 = C_RATE1_DEF,
  parameter int unsigned C_RATE2 = C_RATE2_DEF,
  parameter int unsigned C_RATE3 = C_RATE3_DEF
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_enable,
  input  logic [N_CH-1:0]            i_ch_enable,
  input  logic [RATE_SEL_W*N_CH-1:0] i_rate_sel,
  output logic [N_CH-1:0]            o_led_drive,
  output logic [NUM_RATES-1:0]       o_dbg_rate
);

  localparam int unsigned C_HALF [NUM_RATES] = '{C_RATE0, C_RATE1, C_RATE2, C_RATE3};

  logic                       en_use;
  logic [N_CH-1:0]            ch_en_use;
  logic [RATE_SEL_W*N_CH-1:0] rate_sel_use;
  logic [NUM_RATES-1:0]       sq;

`ifdef LED_BLINKER_MULTI_SYNC_EN
  logic                       en_p0, en_p1;
  logic [N_CH-1:0]            ch_en_p0, ch_en_p1;
  logic [RATE_SEL_W*N_CH-1:0] sel_p0, sel_p1;

  // Stage p0 -> p1: two-flop synchroniser for switch inputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_p0    <= 1'b0;
      en_p1    <= 1'b0;
      ch_en_p0 <= '0;
      ch_en_p1 <= '0;
      sel_p0   <= '0;
      sel_p1   <= '0;
    end else begin
      en_p0    <= i_enable;
      en_p1    <= en_p0;
      ch_en_p0 <= i_ch_enable;
      ch_en_p1 <= ch_en_p0;
      sel_p0   <= i_rate_sel;
      sel_p1   <= sel_p0;
    end
  end

  assign en_use       = en_p1;
  assign ch_en_use    = ch_en_p1;
  assign rate_sel_use = sel_p1;
`else
  assign en_use       = i_enable;
  assign ch_en_use    = i_ch_enable;
  assign rate_sel_use = i_rate_sel;
`endif

  // Stage: shared rate generators
  for (genvar k = 0; k < NUM_RATES; k++) begin : g_rate
    led_rate_gen #(
      .CNT_W  (CNT_W),
      .C_HALF (C_HALF[k])
    ) u_rate_gen (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_enable  (en_use),
      .o_sq      (sq[k])
    );
  end

  assign o_dbg_rate = sq;

  // Stage: per-channel select tracking and LED output register
  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    rate_sel_e cur_sel;
    rate_sel_e req_sel;
    logic      can_switch;
    logic      led_q;

    assign req_sel = rate_sel_e'(rate_sel_use[RATE_SEL_W*n +: RATE_SEL_W]);

    // A new rate is only held off while this channel's LED is visibly in a
    // high pulse; a dark channel may switch immediately. sq is the registered
    // value, so a toggle on the same edge is not seen yet.
    assign can_switch = ~sq[cur_sel] | ~ch_en_use[n] | ~en_use;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        cur_sel <= RATE_100HZ;
        led_q   <= 1'b0;
      end else begin
        led_q <= en_use & ch_en_use[n] & sq[cur_sel];
        if ((req_sel != cur_sel) && can_switch) begin
          cur_sel <= req_sel;
        end
      end
    end

    assign o_led_drive[n] = led_q;
  end

endmodule
